// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the I/D memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gnt_t;

  localparam int BURST_LEN_DEF = 8;
  localparam int OFF_W         = $clog2(BURST_LEN_DEF);

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between the I and D miss handlers for the shared
// single-ported 16-bit memory. Reads become aligned BURST_LEN-word line
// fills, D writes become a single-word write-through.
//
// state | meaning
// IDLE  | sample requests, pick a side, latch address/data
// FILL  | issue one line word per cycle, offset 0..BURST_LEN-1
// WRITE | single-cycle memory write of the latched D word
// DONE  | last fill word visible, done pulse, flip last-grant pointer
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int BURST_LEN  = BURST_LEN_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_req,
  input  logic [ADDR_WIDTH-1:0]        i_addr,
  input  logic                         d_req,
  input  logic                         d_wr,
  input  logic [ADDR_WIDTH-1:0]        d_addr,
  input  logic [15:0]                  d_wdata,
  output logic                         i_rvalid,
  output logic                         d_rvalid,
  output logic [15:0]                  rdata,
  output logic [$clog2(BURST_LEN)-1:0] rword,
  output logic                         i_done,
  output logic                         d_done,
  output logic                         mem_en,
  output logic                         mem_wr,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  output logic [15:0]                  mem_wdata,
  input  logic [15:0]                  mem_rdata
);

  localparam int OW = $clog2(BURST_LEN);
  localparam logic [OW-1:0] LAST_OFF = OW'(BURST_LEN - 1);

  state_t                state_q, state_d;
  gnt_t                  gnt_q, last_q, gnt_pick;
  logic [ADDR_WIDTH-1:1] addr_q;
  logic [15:0]           wdata_q;
  logic [OW-1:0]         off_q;
  logic                  i_rvalid_q, d_rvalid_q;
  logic [15:0]           rdata_q;
  logic [OW-1:0]         rword_q;

  // Round-robin pick: on a tie the side not served last wins.
  always_comb begin
    gnt_pick = GNT_I;
    if (d_req && (!i_req || last_q == GNT_I)) gnt_pick = GNT_D;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_req || d_req) state_d = (gnt_pick == GNT_D && d_wr) ? WRITE : FILL;
      FILL:    if (off_q == LAST_OFF) state_d = DONE;
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant/address latch, burst offset counter and registered read return.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q      <= GNT_I;
      last_q     <= GNT_I;
      addr_q     <= '0;
      wdata_q    <= '0;
      off_q      <= '0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      rdata_q    <= '0;
      rword_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (i_req || d_req) begin
          gnt_q   <= gnt_pick;
          addr_q  <= (gnt_pick == GNT_D) ? d_addr[ADDR_WIDTH-1:1] : i_addr[ADDR_WIDTH-1:1];
          wdata_q <= d_wdata;
          off_q   <= '0;
        end
        FILL:    off_q  <= off_q + 1'b1;
        DONE:    last_q <= gnt_q;
        default: ;
      endcase
      i_rvalid_q <= (state_q == FILL) && (gnt_q == GNT_I);
      d_rvalid_q <= (state_q == FILL) && (gnt_q == GNT_D);
      if (state_q == FILL) begin
        rdata_q <= mem_rdata;
        rword_q <= off_q;
      end
    end
  end

  // Memory pins and done pulses decoded from the current state.
  always_comb begin
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    i_done    = 1'b0;
    d_done    = 1'b0;
    case (state_q)
      FILL: begin
        mem_en   = 1'b1;
        mem_addr = {addr_q[ADDR_WIDTH-1:OW+1], off_q, 1'b0};
      end
      WRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = {addr_q, 1'b0};
        mem_wdata = wdata_q;
      end
      DONE: begin
        i_done = (gnt_q == GNT_I);
        d_done = (gnt_q == GNT_D);
      end
      default: ;
    endcase
  end

  assign i_rvalid = i_rvalid_q;
  assign d_rvalid = d_rvalid_q;
  assign rdata    = rdata_q;
  assign rword    = rword_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by
// randomized transactions, checked against a transaction-level model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_wr;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic        i_rvalid, d_rvalid, i_done, d_done;
  logic [15:0] rdata;
  logic [2:0]  rword;
  logic        mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  logic [15:0] mem     [0:32767];
  logic [15:0] ref_mem [0:32767];

  int errors = 0;
  int checks = 0;
  bit last_d;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(16), .BURST_LEN(8)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .i_rvalid(i_rvalid), .d_rvalid(d_rvalid), .rdata(rdata), .rword(rword),
    .i_done(i_done), .d_done(d_done),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[15:1]];

  always @(posedge clk) if (mem_en && mem_wr) mem[mem_addr[15:1]] <= mem_wdata;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_i_rvalid"}, 32'(i_rvalid), 0);
    chk({tag, "_d_rvalid"}, 32'(d_rvalid), 0);
    chk({tag, "_rdata"}, 32'(rdata), 0);
    chk({tag, "_rword"}, 32'(rword), 0);
    chk({tag, "_i_done"}, 32'(i_done), 0);
    chk({tag, "_d_done"}, 32'(d_done), 0);
    chk({tag, "_mem_en"}, 32'(mem_en), 0);
    chk({tag, "_mem_wr"}, 32'(mem_wr), 0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_en"}, 32'(mem_en), 0);
    chk({tag, "_done"}, 32'({i_done, d_done}), 0);
    chk({tag, "_rvalid"}, 32'({i_rvalid, d_rvalid}), 0);
  endtask

  // Round-robin rule: lone requester wins; on a tie the side not served last.
  function automatic bit pick_d();
    if (d_req && i_req) return !last_d;
    return d_req;
  endfunction

  // Runs one transaction starting from a negedge in IDLE with requests driven.
  // drop_at: offset at which the granted side releases its request (-1 none).
  // abort_at: offset at which reset is pulsed (-1 none).
  // keep: leave both requests asserted after done.
  task automatic do_txn(input string tag, input int drop_at, input int abort_at, input bit keep);
    bit          side_d, is_wr, aborted;
    logic [15:0] a, base, wd;
    int          idx;
    side_d  = pick_d();
    is_wr   = side_d && d_wr;
    a       = side_d ? d_addr : i_addr;
    wd      = d_wdata;
    base    = a & 16'hFFF0;
    aborted = 1'b0;
    @(negedge clk);
    if (is_wr) begin
      chk({tag, "_wr_en"}, 32'({mem_en, mem_wr}), 32'h3);
      chk({tag, "_wr_addr"}, 32'(mem_addr), 32'(a & 16'hFFFE));
      chk({tag, "_wr_data"}, 32'(mem_wdata), 32'(wd));
      chk({tag, "_wr_done"}, 32'({i_done, d_done}), 0);
      ref_mem[a[15:1]] = wd;
      @(negedge clk);
    end else begin
      for (int k = 0; k < 8 && !aborted; k++) begin
        chk({tag, "_fill_en"}, 32'({mem_en, mem_wr}), 32'h2);
        chk({tag, "_fill_addr"}, 32'(mem_addr), 32'(base + 16'(2 * k)));
        chk({tag, "_fill_done"}, 32'({i_done, d_done}), 0);
        if (k == 0) begin
          chk({tag, "_rv0"}, 32'({i_rvalid, d_rvalid}), 0);
        end else begin
          idx = int'(base[15:1]) + k - 1;
          chk({tag, "_rv"}, 32'({i_rvalid, d_rvalid}), side_d ? 32'h1 : 32'h2);
          chk({tag, "_rword"}, 32'(rword), 32'(k - 1));
          chk({tag, "_rdata"}, 32'(rdata), 32'(ref_mem[idx]));
        end
        if (k == drop_at) begin
          if (side_d) d_req = 1'b0;
          else        i_req = 1'b0;
        end
        if (k == abort_at) begin
          rst = 1'b1; i_req = 1'b0; d_req = 1'b0;
          @(negedge clk);
          chk_zero({tag, "_abort"});
          rst    = 1'b0;
          last_d = 1'b0;
          aborted = 1'b1;
        end else begin
          @(negedge clk);
        end
      end
      if (!aborted) begin
        idx = int'(base[15:1]) + 7;
        chk({tag, "_rv_last"}, 32'({i_rvalid, d_rvalid}), side_d ? 32'h1 : 32'h2);
        chk({tag, "_rword_last"}, 32'(rword), 7);
        chk({tag, "_rdata_last"}, 32'(rdata), 32'(ref_mem[idx]));
      end
    end
    if (!aborted) begin
      chk({tag, "_done"}, 32'({i_done, d_done}), side_d ? 32'h1 : 32'h2);
      chk({tag, "_done_en"}, 32'(mem_en), 0);
      last_d = side_d;
      if (!keep) begin
        if (side_d) d_req = 1'b0;
        else        i_req = 1'b0;
      end
      @(negedge clk);
      chk_idle({tag, "_post"});
    end
  endtask

  initial begin
    for (int w = 0; w < 32768; w++) begin
      mem[w]     = 16'(w * 40503 + 4660);
      ref_mem[w] = 16'(w * 40503 + 4660);
    end
    rst = 1'b1; i_req = 0; d_req = 0; d_wr = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0;
    last_d = 1'b0;

    // 1: reset, idle, lone I fill
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_zero("idle");
    i_req = 1; i_addr = 16'h0036;
    do_txn("t1_ifill", -1, -1, 0);

    // 2: tie after reset -> D first, then I, then tie again
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; last_d = 1'b0;
    @(negedge clk);
    d_req = 1; d_wr = 0; d_addr = 16'h1000;
    i_req = 1; i_addr = 16'h2000;
    do_txn("t2_tie_d", -1, -1, 0);
    do_txn("t2_then_i", -1, -1, 0);
    d_req = 1; i_req = 1; i_addr = 16'h2010; d_addr = 16'h1010;
    do_txn("t2_tie2", -1, -1, 0);
    i_req = 0; d_req = 0;

    // 3: D write then D fill of the same line
    d_req = 1; d_wr = 1; d_addr = 16'h0101; d_wdata = 16'hBEEF;
    do_txn("t3_write", -1, -1, 0);
    d_req = 1; d_wr = 0; d_addr = 16'h0100;
    do_txn("t3_readback", -1, -1, 0);

    // 4: both held continuously -> alternate grants
    d_req = 1; d_wr = 0; d_addr = 16'h3000; i_req = 1; i_addr = 16'h4002;
    for (int n = 0; n < 4; n++) do_txn("t4_starve", -1, -1, 1);
    i_req = 0; d_req = 0;
    @(negedge clk);
    chk_idle("t4_quiet");

    // 5: reset mid-fill, then a fresh fill from offset 0
    i_req = 1; i_addr = 16'h5020;
    do_txn("t5_abort", -1, 3, 0);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk_idle("t5_nodone");
    end
    i_req = 1; i_addr = 16'h5020;
    do_txn("t5_refill", -1, -1, 0);

    // 6: requester drops mid-burst
    i_req = 1; i_addr = 16'h6044;
    do_txn("t6_drop", 2, -1, 0);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk_idle("t6_nogrant");
    end

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      i_req   = 1'($urandom_range(0, 1));
      d_req   = 1'($urandom_range(0, 1));
      d_wr    = 1'($urandom_range(0, 1));
      i_addr  = 16'($urandom_range(0, 16'h01FF));
      d_addr  = 16'($urandom_range(0, 16'h01FF));
      d_wdata = 16'($urandom);
      if (!i_req && !d_req) begin
        @(negedge clk);
        chk_idle("rnd_idle");
      end else begin
        do_txn("rnd", -1, -1, 0);
      end
    end
    i_req = 0; d_req = 0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
